// File: rtl/synthesijer_mul32_arbiter.sv
// Four-requester arbiter in front of one shared 32x32 signed multiplier.
// Each requester latches its operands on nd when ready. A round-robin
// grant picks one pending requester per cycle. The low 32 bits of the
// product come out LATENCY cycles later, tagged one-hot on valid.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   a, b   : 4 x 32-bit signed operands, requester i uses [32*i +: 32]
//   nd     : per-requester new-data strobe
//   ready  : per-requester accept-ready (= not pending)
//   result : shared product bus, holds its value between results
//   valid  : one-hot owner tag of result, one cycle per product
//   idle   : nothing pending and nothing in flight
module synthesijer_mul32_arbiter #(
    parameter int LATENCY = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] a,
    input  logic [127:0] b,
    input  logic [3:0]   nd,
    output logic [3:0]   ready,
    output logic [31:0]  result,
    output logic [3:0]   valid,
    output logic         idle
);

    logic [3:0]  pend_q;
    logic [3:0]  pend_d;
    logic [31:0] opa_q [4];
    logic [31:0] opb_q [4];
    logic [1:0]  ptr_q;
    logic [1:0]  ptr_d;

    logic [3:0]  gnt;
    logic [1:0]  gidx;
    logic        gany;
    logic [1:0]  cand;
    logic [31:0] prod;

    logic [31:0] res_q [LATENCY];
    logic [3:0]  tag_q [LATENCY];
    logic        busy;

    // Round-robin search starting at ptr_q, wrapping 3 -> 0.
    always_comb begin
        gany = 1'b0;
        gidx = ptr_q;
        cand = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!gany && pend_q[cand]) begin
                gany = 1'b1;
                gidx = cand;
            end
        end
        gnt = gany ? (4'b0001 << gidx) : 4'b0000;
    end

    // Low 32 bits of a two's-complement product do not depend on
    // signedness, so a 32-bit multiply yields the wrapped signed result.
    assign prod = opa_q[gidx] * opb_q[gidx];

    // The granted bit is always set in pend_q, so it can never be
    // re-accepted on the same edge it is cleared.
    always_comb begin
        pend_d = (pend_q & ~gnt) | (nd & ~pend_q);
        ptr_d  = gany ? gidx + 2'd1 : ptr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
            ptr_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                opa_q[i] <= '0;
                opb_q[i] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            ptr_q  <= ptr_d;
            for (int i = 0; i < 4; i++) begin
                if (nd[i] && !pend_q[i]) begin
                    opa_q[i] <= a[32*i +: 32];
                    opb_q[i] <= b[32*i +: 32];
                end
            end
        end
    end

    // Data only moves with a valid tag, so the last stage holds the
    // previous product while no result is due.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LATENCY; k++) begin
                res_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= gnt;
            if (gany) begin
                res_q[0] <= prod;
            end
            for (int k = 1; k < LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
                if (|tag_q[k-1]) begin
                    res_q[k] <= res_q[k-1];
                end
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < LATENCY; k++) begin
            busy = busy | (|tag_q[k]);
        end
    end

    assign ready  = ~pend_q;
    assign valid  = tag_q[LATENCY-1];
    assign result = res_q[LATENCY-1];
    assign idle   = ~(|pend_q) & ~busy;

endmodule

// File: tb/tb_synthesijer_mul32_arbiter.sv
// Randomized and directed bench for synthesijer_mul32_arbiter against
// a cycle-indexed schedule model of the arbiter and multiplier.
module tb_synthesijer_mul32_arbiter;

    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] a;
    logic [127:0] b;
    logic [3:0]   nd;
    logic [3:0]   ready;
    logic [31:0]  result;
    logic [3:0]   valid;
    logic         idle;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model state
    logic [3:0]  m_pend;
    logic [31:0] m_a [4];
    logic [31:0] m_b [4];
    int          m_ptr;
    logic [31:0] m_last;
    logic [3:0]  xv [int];
    logic [31:0] xr [int];

    logic [3:0]  e_ready;
    logic [3:0]  e_valid;
    logic [31:0] e_res;
    logic        e_idle;

    synthesijer_mul32_arbiter #(.LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .nd(nd),
        .ready(ready), .result(result), .valid(valid), .idle(idle)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mul(input logic [31:0] x,
                                        input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return p[31:0];
    endfunction

    task automatic mdl_clear();
        m_pend = '0;
        m_ptr  = 0;
        m_last = '0;
        xv.delete();
        xr.delete();
        for (int i = 0; i < 4; i++) begin
            m_a[i] = '0;
            m_b[i] = '0;
        end
    endtask

    // One rising edge: serve one pending requester, then accept new ones.
    task automatic mdl_edge();
        logic [3:0] pre;
        int i;
        if (!reset) begin
            mdl_clear();
        end else begin
            pre = m_pend;
            for (int k = 0; k < 4; k++) begin
                i = (m_ptr + k) % 4;
                if (m_pend[i]) begin
                    xv[cyc + LAT] = 4'b0001 << i;
                    xr[cyc + LAT] = mul(m_a[i], m_b[i]);
                    m_pend[i] = 1'b0;
                    m_ptr = (i + 1) % 4;
                    break;
                end
            end
            for (int j = 0; j < 4; j++) begin
                if (nd[j] && !pre[j]) begin
                    m_a[j] = a[32*j +: 32];
                    m_b[j] = b[32*j +: 32];
                    m_pend[j] = 1'b1;
                end
            end
        end
        cyc++;
    endtask

    task automatic mdl_out();
        bit inflight;
        inflight = 1'b0;
        foreach (xv[k]) if (k >= cyc) inflight = 1'b1;
        e_ready = ~m_pend;
        if (xv.exists(cyc)) begin
            e_valid = xv[cyc];
            m_last  = xr[cyc];
        end else begin
            e_valid = '0;
        end
        e_res  = m_last;
        e_idle = (m_pend == 0) && !inflight;
    endtask

    task automatic tick(input logic [3:0] n, input logic [127:0] av,
                        input logic [127:0] bv);
        nd = n;
        a  = av;
        b  = bv;
        @(posedge clk);
        mdl_edge();
        #1;
        mdl_out();
    endtask

    task automatic hold_reset();
        reset = 1'b0;
        #1;
        mdl_clear();
        mdl_out();
        tick(4'b0000, '0, '0);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        tick(4'b0000, '0, '0);
        total++;
        if ({ready, valid, result, idle} !== {4'hF, 4'h0, 32'h0, 1'b1}) begin
            bad++;
            $display("FAIL reset r=%b v=%b res=%h i=%b want 1111 0000 0 1",
                     ready, valid, result, idle);
        end
        reset = 1'b1;
        tick(4'b0001, {96'h0, 32'd4}, {96'h0, 32'd5});
        total++;
        if (ready[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset.first_accept ready0=%b want 0", ready[0]);
        end
        for (int j = 0; j < 6; j++) begin
            tick(4'b0000, '0, '0);
            total++;
            if ({ready, valid, result, idle} !==
                {e_ready, e_valid, e_res, e_idle}) begin
                bad++;
                $display("FAIL reset.model cyc=%0d got %b %b %h %b want %b %b %h %b",
                         cyc, ready, valid, result, idle,
                         e_ready, e_valid, e_res, e_idle);
            end
        end
    endtask

    task automatic test_single();
        logic [127:0] av;
        logic [127:0] bv;
        av = '0;
        bv = '0;
        av[95:64] = 32'd7;
        bv[95:64] = 32'hFFFF_FFFA;
        tick(4'b0100, av, bv);
        total++;
        if (ready[2] !== 1'b0) begin
            bad++;
            $display("FAIL single.ready_low got=%b want 0", ready[2]);
        end
        for (int j = 2; j <= 7; j++) begin
            tick(4'b0000, '0, '0);
            total++;
            if ({ready, valid, result, idle} !==
                {e_ready, e_valid, e_res, e_idle}) begin
                bad++;
                $display("FAIL single.model cyc=%0d got %b %b %h %b want %b %b %h %b",
                         cyc, ready, valid, result, idle,
                         e_ready, e_valid, e_res, e_idle);
            end
            if (j == 2) begin
                total++;
                if (ready[2] !== 1'b1) begin
                    bad++;
                    $display("FAIL single.ready_back got=%b want 1", ready[2]);
                end
            end
            if (j == 4) begin
                total++;
                if (valid !== 4'b0100 || result !== 32'hFFFF_FFD6) begin
                    bad++;
                    $display("FAIL single.result got v=%b r=%h want 0100 ffffffd6",
                             valid, result);
                end
            end
        end
    endtask

    task automatic test_contention();
        logic [127:0] av;
        logic [127:0] bv;
        logic [3:0]   wv;
        hold_reset();
        for (int i = 0; i < 4; i++) begin
            av[32*i +: 32] = 32'(i + 1);
            bv[32*i +: 32] = 32'd10;
        end
        tick(4'b1111, av, bv);
        for (int j = 2; j <= 9; j++) begin
            tick(4'b0000, '0, '0);
            total++;
            if ({ready, valid, result, idle} !==
                {e_ready, e_valid, e_res, e_idle}) begin
                bad++;
                $display("FAIL contention.model cyc=%0d got %b %b %h %b want %b %b %h %b",
                         cyc, ready, valid, result, idle,
                         e_ready, e_valid, e_res, e_idle);
            end
            if (j >= 4 && j <= 7) begin
                wv = 4'b0001 << (j - 4);
                total++;
                if (valid !== wv || result !== 32'((j - 3) * 10)) begin
                    bad++;
                    $display("FAIL contention.seq t+%0d got v=%b r=%0d want %b %0d",
                             j, valid, result, wv, (j - 3) * 10);
                end
            end
        end
    endtask

    task automatic test_fairness();
        int seq [$];
        int first3;
        int second0;
        int n0;
        hold_reset();
        seq.delete();
        for (int j = 0; j < 16; j++) begin
            tick((j == 1) ? 4'b1111 : (j < 10 ? 4'b0111 : 4'b0000),
                 {4{$urandom}}, {4{$urandom}});
            total++;
            if ({ready, valid, result, idle} !==
                {e_ready, e_valid, e_res, e_idle}) begin
                bad++;
                $display("FAIL fairness.model cyc=%0d got %b %b %h %b want %b %b %h %b",
                         cyc, ready, valid, result, idle,
                         e_ready, e_valid, e_res, e_idle);
            end
            if (valid != 0) seq.push_back(int'(valid));
        end
        first3  = 99;
        second0 = 99;
        n0 = 0;
        foreach (seq[k]) begin
            if (seq[k] == 8 && first3 == 99) first3 = k;
            if (seq[k] == 1) begin
                n0++;
                if (n0 == 2) second0 = k;
            end
        end
        total++;
        if (!(first3 < second0)) begin
            bad++;
            $display("FAIL fairness.order pos3=%0d pos0b=%0d want pos3<pos0b",
                     first3, second0);
        end
    endtask

    task automatic test_wrap();
        logic [127:0] av;
        logic [127:0] bv;
        logic [31:0]  r0;
        logic [31:0]  r1;
        av = '0;
        bv = '0;
        av[31:0]  = 32'h7FFF_FFFF;
        bv[31:0]  = 32'd2;
        av[63:32] = 32'h8000_0000;
        bv[63:32] = 32'hFFFF_FFFF;
        r0 = 'x;
        r1 = 'x;
        tick(4'b0011, av, bv);
        for (int j = 0; j < 8; j++) begin
            tick(4'b0000, '0, '0);
            total++;
            if ({ready, valid, result, idle} !==
                {e_ready, e_valid, e_res, e_idle}) begin
                bad++;
                $display("FAIL wrap.model cyc=%0d got %b %b %h %b want %b %b %h %b",
                         cyc, ready, valid, result, idle,
                         e_ready, e_valid, e_res, e_idle);
            end
            if (valid == 4'b0001) r0 = result;
            if (valid == 4'b0010) r1 = result;
        end
        total++;
        if (r0 !== 32'hFFFF_FFFE || r1 !== 32'h8000_0000) begin
            bad++;
            $display("FAIL wrap.values got %h %h want fffffffe 80000000", r0, r1);
        end
    endtask

    task automatic test_blocked();
        logic [127:0] av;
        logic [127:0] bv;
        int cnt;
        logic [31:0] got;
        cnt = 0;
        got = 'x;
        av = '0;
        bv = '0;
        av[63:32] = 32'd3;
        bv[63:32] = 32'd3;
        tick(4'b0010, av, bv);
        av[63:32] = 32'd9;
        bv[63:32] = 32'd9;
        tick(4'b0010, av, bv);
        for (int j = 0; j < 8; j++) begin
            if (valid == 4'b0010) begin
                cnt++;
                got = result;
            end
            total++;
            if ({ready, valid, result, idle} !==
                {e_ready, e_valid, e_res, e_idle}) begin
                bad++;
                $display("FAIL blocked.model cyc=%0d got %b %b %h %b want %b %b %h %b",
                         cyc, ready, valid, result, idle,
                         e_ready, e_valid, e_res, e_idle);
            end
            tick(4'b0000, '0, '0);
        end
        total++;
        if (cnt != 1 || got !== 32'd9) begin
            bad++;
            $display("FAIL blocked.single got count=%0d res=%0d want 1 9", cnt, got);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] av;
        logic [127:0] bv;
        logic [31:0]  got;
        av = '0;
        bv = '0;
        av[95:64] = 32'd11;
        bv[95:64] = 32'd13;
        tick(4'b0100, av, bv);
        tick(4'b0000, '0, '0);
        hold_reset();
        for (int j = 0; j < 6; j++) begin
            tick(4'b0000, '0, '0);
            total++;
            if (valid !== 4'h0 || ready !== 4'hF || idle !== 1'b1) begin
                bad++;
                $display("FAIL reset_mid.quiet got v=%b r=%b i=%b want 0000 1111 1",
                         valid, ready, idle);
            end
        end
        av[63:32] = 32'd5;
        bv[63:32] = 32'hFFFF_FFFD;
        got = 'x;
        tick(4'b0010, av, bv);
        for (int j = 0; j < 6; j++) begin
            tick(4'b0000, '0, '0);
            if (valid == 4'b0010) got = result;
        end
        total++;
        if (got !== 32'hFFFF_FFF1) begin
            bad++;
            $display("FAIL reset_mid.after got=%h want fffffff1", got);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 400; j++) begin
            tick(4'($urandom), {4{$urandom}},
                 {$urandom, 32'hFFFF_FFFF, $urandom, 32'($urandom_range(0, 9))});
            total++;
            if ({ready, valid, result, idle} !==
                {e_ready, e_valid, e_res, e_idle}) begin
                bad++;
                $display("FAIL random.model cyc=%0d got %b %b %h %b want %b %b %h %b",
                         cyc, ready, valid, result, idle,
                         e_ready, e_valid, e_res, e_idle);
            end
        end
        for (int j = 0; j < 10; j++) begin
            tick(4'b0000, '0, '0);
        end
        total++;
        if (idle !== 1'b1 || valid !== 4'h0) begin
            bad++;
            $display("FAIL random.drain got i=%b v=%b want 1 0000", idle, valid);
        end
    endtask

    initial begin
        reset = 1'b0;
        nd = '0;
        a = '0;
        b = '0;
        mdl_clear();
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_wrap();
        test_blocked();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
